// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared MNIST CNN constants, sample type and signed max helper
package mnist_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int CONV1_CH   = 8;
    localparam int CONV2_CH   = 16;
    localparam int IMG_28     = 28;
    localparam int IMG_24     = 24;
    localparam int IMG_12     = 12;
    localparam int IMG_8      = 8;
    localparam int IMG_4      = 4;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

    // Callers sign-extend narrower samples to 32 bits and truncate the result back.
    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_layer_if.sv
// rtl/maxpool_layer_if.sv - pixel stream in/out bundle for the max-pooling stage
interface maxpool_layer_if
    import mnist_pkg::*;
#(
    parameter int CHANNELS = CONV1_CH,
    parameter int DATA_W   = DEF_DATA_W
);
    logic                         valid_in;
    logic [CHANNELS*DATA_W-1:0]   data_in;
    logic                         valid_out;
    logic [CHANNELS*DATA_W-1:0]   data_out;
    logic                         last_out;

    modport master (output valid_in, data_in, input valid_out, data_out, last_out);
    modport slave  (input valid_in, data_in, output valid_out, data_out, last_out);
endinterface

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - half-width line buffer holding horizontal maxima of the even row
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 64,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_valid
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_valid;

    // No reset on the storage so it maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_valid <= 1'b0;
        else if (i_wr_en)
            r_valid <= 1'b1;
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_valid   = r_valid;
endmodule

// File: rtl/maxpool_layer.sv
// rtl/maxpool_layer.sv - streaming 2x2 stride-2 max pooling; MAXPOOL_RELU_EN fuses a ReLU on the output
module maxpool_layer
    import mnist_pkg::*;
#(
    parameter int CHANNELS = CONV1_CH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IMG_W    = IMG_28,
    parameter int IMG_H    = IMG_28
) (
    input  logic            clk,
    input  logic            rst,
    maxpool_layer_if.slave  bus
);
    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int PW       = CHANNELS * DATA_W;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int LAST_COL = (IMG_W / 2) * 2 - 1;
    localparam int LAST_ROW = (IMG_H / 2) * 2 - 1;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PW-1:0]    r_hold;
    logic [PW-1:0]    r_data_out;
    logic             r_valid_out;
    logic             r_last_out;

    logic             w_col_end;
    logic             w_row_end;
    logic             w_lb_wr;
    logic             w_emit;
    logic             w_last;
    logic             w_lb_valid;
    logic [LB_AW-1:0] w_lb_addr;
    logic [PW-1:0]    w_h;
    logic [PW-1:0]    w_lb_rd;
    logic [PW-1:0]    w_res;

    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    assign w_lb_addr = LB_AW'(r_col >> 1);
    assign w_lb_wr   = bus.valid_in & r_col[0] & ~r_row[0];
    // Odd dimensions never reach an odd index past the last full window, so no range check.
    assign w_emit    = bus.valid_in & r_col[0] & r_row[0] & w_lb_valid;
    assign w_last    = (r_row == RW'(LAST_ROW)) && (r_col == CW'(LAST_COL));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic signed [DATA_W-1:0] w_hold_s;
        logic signed [DATA_W-1:0] w_pix_s;
        logic signed [DATA_W-1:0] w_h_s;
        logic signed [DATA_W-1:0] w_lb_s;
        logic signed [DATA_W-1:0] w_max_s;

        assign w_hold_s = r_hold[g*DATA_W +: DATA_W];
        assign w_pix_s  = bus.data_in[g*DATA_W +: DATA_W];
        assign w_h_s    = DATA_W'(smax(32'(w_hold_s), 32'(w_pix_s)));
        assign w_lb_s   = w_lb_rd[g*DATA_W +: DATA_W];
        assign w_max_s  = DATA_W'(smax(32'(w_h_s), 32'(w_lb_s)));

        assign w_h[g*DATA_W +: DATA_W] = w_h_s;
`ifdef MAXPOOL_RELU_EN
        assign w_res[g*DATA_W +: DATA_W] = w_max_s[DATA_W-1] ? '0 : w_max_s;
`else
        assign w_res[g*DATA_W +: DATA_W] = w_max_s;
`endif
    end

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .WIDTH (PW),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_lb_wr),
        .i_wr_addr (w_lb_addr),
        .i_wr_data (w_h),
        .i_rd_addr (w_lb_addr),
        .o_rd_data (w_lb_rd),
        .o_valid   (w_lb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            if (bus.valid_in) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (!r_col[0])
                    r_hold <= bus.data_in;
                if (w_emit) begin
                    r_data_out  <= w_res;
                    r_valid_out <= 1'b1;
                    r_last_out  <= w_last;
                end
            end
        end
    end

    assign bus.valid_out = r_valid_out;
    assign bus.data_out  = r_data_out;
    assign bus.last_out  = r_last_out;
endmodule
